// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped I-cache sequencer.
// Geometry: 128 lines x 32 B, 20-bit tag, 7-bit index, 3-bit word offset.
// Address field positions and the sequencer state encoding live here.
package icache_pkg;
  localparam int TAG_W      = 20;
  localparam int INDEX_W    = 7;
  localparam int LINE_WORDS = 8;
  localparam int OFF_W      = 3;
  localparam int TAG_LSB    = 12;
  localparam int IDX_LSB    = 5;
  localparam int OFF_LSB    = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_TAGWR,
    ST_RESP
  } state_t;
endpackage

// File: rtl/icache_axi_rd.sv
// AXI read-burst helper: AR handshake and R-beat counting for one line refill.
// Latency: purely combinational strobes; the beat counter advances on each accepted beat.
// Backpressure: arvalid held while ar_start until arready; rready held while r_active.
module icache_axi_rd
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ar_start,
  input  logic             r_active,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             arvalid,
  output logic             ar_done,
  output logic             rready,
  output logic             beat,
  output logic [OFF_W-1:0] offset,
  output logic             done
);
  logic [OFF_W-1:0] cnt;

  assign arvalid = ar_start;
  assign ar_done = ar_start & arready;
  assign rready  = r_active;
  assign beat    = r_active & rvalid;
  assign done    = beat & rlast;
  assign offset  = cnt;

  // Beat counter: wraps naturally at 8, cleared on the last beat so the next burst starts at 0.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (beat) cnt <= rlast ? '0 : cnt + 3'd1;
  end
endmodule

// File: rtl/icache_ctrl.sv
// I-cache sequencer: tag lookup, 8-beat AXI line refill on miss, tag write, CPU response.
// Latency: hit returns data the cycle after accept; miss = 2 + AR wait + 8 beats + 2 cycles.
// Backpressure: requests are only accepted in INIT/IDLE with tag_work high; AXI waits stall the FSM.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic [31:0] tag_addr,
  output logic        tag_wen,
  output logic [20:0] tag_wdata,
  input  logic        tag_hit,
  input  logic        tag_valid,
  input  logic        tag_work,
  output logic [6:0]  dram_index,
  output logic [2:0]  dram_offset,
  output logic        dram_wen,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  output logic        rready
);
  state_t      state, state_nxt;
  logic [31:0] req_addr;
  logic [31:0] rdata_q;
  logic [31:0] addr_sel;
  logic        accept, hit, ar_start, r_active;
  logic        ar_done, beat, done;
  logic [2:0]  beat_off;

  // INIT accepts as soon as tag_work rises so the first fetch is not delayed a cycle.
  assign accept      = !rst && tag_work && cpu_req && (state == ST_IDLE || state == ST_INIT);
  assign cpu_addr_ok = accept;
  assign hit         = tag_hit & tag_valid;
  assign ar_start    = (state == ST_MISS);
  assign r_active    = (state == ST_REFILL);

  // Tag array and data RAM see the incoming address on the accept cycle, the latched one otherwise.
  assign addr_sel    = accept ? cpu_addr : req_addr;
  assign tag_addr    = addr_sel;
  assign tag_wdata   = {1'b1, req_addr[31:TAG_LSB]};
  assign dram_index  = addr_sel[IDX_LSB +: INDEX_W];
  assign dram_offset = r_active ? beat_off : addr_sel[OFF_LSB +: OFF_W];
  assign dram_wen    = beat;
  assign dram_wdata  = rdata;
  assign araddr      = {req_addr[31:IDX_LSB], 5'b0};
  assign arlen       = 8'd7;
  assign arsize      = 3'b010;

  // On a hit the RAM read word goes straight out; otherwise the captured word is presented.
  assign cpu_rdata   = (state == ST_LOOKUP) ? dram_rdata : rdata_q;

  icache_axi_rd u_axi_rd (
    .clk      (clk),
    .rst      (rst),
    .ar_start (ar_start),
    .r_active (r_active),
    .arready  (arready),
    .rvalid   (rvalid),
    .rlast    (rlast),
    .arvalid  (arvalid),
    .ar_done  (ar_done),
    .rready   (rready),
    .beat     (beat),
    .offset   (beat_off),
    .done     (done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt   = state;
    tag_wen     = 1'b0;
    cpu_data_ok = 1'b0;
    case (state)
      ST_INIT: begin
        if (accept)        state_nxt = ST_LOOKUP;
        else if (tag_work) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_data_ok = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          state_nxt   = ST_MISS;
        end
      end
      ST_MISS: begin
        if (ar_done) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        if (done) state_nxt = ST_TAGWR;
      end
      ST_TAGWR: begin
        tag_wen   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        cpu_data_ok = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Request address latch and response word capture (hit word or the critical refill beat).
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) req_addr <= cpu_addr;
      if (state == ST_LOOKUP && hit) rdata_q <= dram_rdata;
      if (beat && beat_off == req_addr[OFF_LSB +: OFF_W]) rdata_q <= rdata;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic [31:0] tag_addr;
  logic        tag_wen;
  logic [20:0] tag_wdata;
  logic        tag_hit = 1'b0, tag_valid = 1'b0, tag_work = 1'b0;
  logic [6:0]  dram_index;
  logic [2:0]  dram_offset;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic        rready;

  icache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .tag_addr(tag_addr), .tag_wen(tag_wen), .tag_wdata(tag_wdata),
    .tag_hit(tag_hit), .tag_valid(tag_valid), .tag_work(tag_work),
    .dram_index(dram_index), .dram_offset(dram_offset), .dram_wen(dram_wen),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: tag array and data RAM (1-cycle read latency, write on strobe).
  logic [20:0] tmem [0:127];
  logic [31:0] dmem [0:1023];
  always @(posedge clk) begin
    tag_hit    <= (tmem[tag_addr[11:5]][19:0] == tag_addr[31:12]);
    tag_valid  <= tmem[tag_addr[11:5]][20];
    if (tag_wen) tmem[tag_addr[11:5]] <= tag_wdata;
    dram_rdata <= dmem[{dram_index, dram_offset}];
    if (dram_wen) dmem[{dram_index, dram_offset}] <= dram_wdata;
  end

  // Reference model: per-line valid/tag and a backing-memory function.
  bit          ref_valid [0:127];
  logic [19:0] ref_tag   [0:127];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the last fetch.
  int          obs_acc, obs_lat, obs_narv, obs_nwen, obs_ntag;
  bit          obs_miss, obs_done, obs_aborted;
  logic [20:0] obs_tagw;
  logic [31:0] obs_rdata;

  // Issue one fetch with CPU request held until the response; act as AXI slave.
  task automatic fetch(input logic [31:0] a, input int ar_wait, input int gap, input int abort_beat);
    int cycles, ar_cnt, sent, gapc;
    bit accepted, r_phase, aborting, exp_hit;
    logic [31:0] line;
    exp_hit = ref_valid[a[11:5]] && (ref_tag[a[11:5]] == a[31:12]);
    line = {a[31:5], 5'b0};
    cycles = 0; ar_cnt = 0; sent = 0; gapc = 0;
    accepted = 0; r_phase = 0; aborting = 0;
    obs_acc = 0; obs_lat = 0; obs_narv = 0; obs_nwen = 0; obs_ntag = 0;
    obs_done = 0; obs_aborted = 0; obs_tagw = '0; obs_rdata = '0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = a; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    while (!obs_done && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (cpu_addr_ok) begin
        n_cmp++;
        if (accepted) begin n_bad++; $display("FAIL addr_ok_while_busy: addr_ok=1 again, required 0 (addr %h)", a); end
        accepted = 1; obs_acc = cyc;
      end
      n_cmp++;
      if (rready !== (r_phase && sent < 8)) begin n_bad++; $display("FAIL rready: got %b required %b", rready, (r_phase && sent < 8)); end
      n_cmp++;
      if (dram_wen !== rvalid) begin n_bad++; $display("FAIL dram_wen: got %b required %b", dram_wen, rvalid); end
      if (arvalid) begin
        obs_narv++;
        n_cmp++;
        if (araddr !== line || arlen !== 8'd7 || arsize !== 3'b010) begin
          n_bad++; $display("FAIL ar_fields: araddr %h len %0d size %0d, required %h 7 2", araddr, arlen, arsize, line);
        end
        if (arready) begin r_phase = 1; gapc = 0; end
        else ar_cnt++;
      end
      if (rvalid) begin
        obs_nwen += dram_wen ? 1 : 0;
        n_cmp++;
        if (dram_offset !== sent[2:0] || dram_index !== a[11:5] || dram_wdata !== rdata) begin
          n_bad++; $display("FAIL refill_write: idx %h off %0d data %h, required %h %0d %h",
                            dram_index, dram_offset, dram_wdata, a[11:5], sent, rdata);
        end
        sent++; gapc = gap;
      end else if (r_phase && gapc > 0) gapc--;
      if (tag_wen) begin
        obs_ntag++; obs_tagw = tag_wdata;
        n_cmp++;
        if (tag_wdata !== {1'b1, a[31:12]} || tag_addr[11:5] !== a[11:5]) begin
          n_bad++; $display("FAIL tag_write: wdata %h idx %h, required %h %h", tag_wdata, tag_addr[11:5], {1'b1, a[31:12]}, a[11:5]);
        end
      end
      if (cpu_data_ok) begin
        obs_done = 1; obs_rdata = cpu_rdata; obs_lat = cyc - obs_acc;
        n_cmp++;
        if (cpu_rdata !== mem_word(a)) begin n_bad++; $display("FAIL fetch_data: addr %h got %h required %h", a, cpu_rdata, mem_word(a)); end
      end
      if (aborting) break;
      if (!obs_done) begin
        @(posedge clk); #1;
        arready = arvalid && (ar_cnt == ar_wait);
        if (r_phase && sent < 8 && gapc == 0) begin
          rvalid = 1'b1; rdata = mem_word(line + 32'(sent * 4)); rlast = (sent == 7);
          if (sent == abort_beat) begin rst = 1'b1; aborting = 1; end
        end else begin
          rvalid = 1'b0; rlast = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    if (aborting) begin
      obs_aborted = 1;
      @(posedge clk); #1;
      rst = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
      return;
    end
    n_cmp++;
    if (!obs_done) begin n_bad++; $display("FAIL fetch_timeout: addr %h no data_ok in 400 cycles, required response", a); return; end
    obs_miss = (obs_narv > 0);
    n_cmp++;
    if (obs_miss !== !exp_hit) begin n_bad++; $display("FAIL hit_miss: addr %h miss=%b required %b", a, obs_miss, !exp_hit); end
    n_cmp++;
    if (exp_hit) begin
      if (obs_lat != 1 || obs_nwen != 0 || obs_ntag != 0) begin
        n_bad++; $display("FAIL hit_shape: lat %0d wen %0d tagw %0d, required 1 0 0", obs_lat, obs_nwen, obs_ntag);
      end
    end else begin
      if (obs_lat != 12 + ar_wait + 7 * gap || obs_nwen != 8 || obs_ntag != 1 || obs_narv != ar_wait + 1) begin
        n_bad++; $display("FAIL miss_shape: lat %0d wen %0d tagw %0d arv %0d, required %0d 8 1 %0d",
                          obs_lat, obs_nwen, obs_ntag, obs_narv, 12 + ar_wait + 7 * gap, ar_wait + 1);
      end
      ref_valid[a[11:5]] = 1; ref_tag[a[11:5]] = a[31:12];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tag_work = 1'b0; cpu_req = 1'b1; cpu_addr = 32'hBFC0_0004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cpu_addr_ok, cpu_data_ok, tag_wen, dram_wen, arvalid, rready} !== 6'b0 || cpu_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: strobes %b rdata %h, required 000000 0",
                        {cpu_addr_ok, cpu_data_ok, tag_wen, dram_wen, arvalid, rready}, cpu_rdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_addr_ok !== 1'b0 || arvalid !== 1'b0) begin
        n_bad++; $display("FAIL init_no_accept: cycle %0d addr_ok %b arvalid %b, required 0 0", i, cpu_addr_ok, arvalid);
      end
    end
    @(posedge clk); #1; tag_work = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cpu_addr_ok !== 1'b1) begin n_bad++; $display("FAIL first_accept: addr_ok %b required 1", cpu_addr_ok); end
    cpu_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_cold_fetch();
    fetch(32'hBFC0_0004, 0, 0, -1);
    n_cmp++;
    if (obs_miss !== 1'b1 || obs_tagw !== 21'h1_BFC00 || obs_lat != 12) begin
      n_bad++; $display("FAIL cold_fetch: miss %b tagw %h lat %0d, required 1 1bfc00 12", obs_miss, obs_tagw, obs_lat);
    end
  endtask

  task automatic test_hit();
    fetch(32'hBFC0_0010, 0, 0, -1);
    n_cmp++;
    if (obs_miss !== 1'b0 || obs_lat != 1 || obs_rdata !== mem_word(32'hBFC0_0010)) begin
      n_bad++; $display("FAIL refetch_hit: miss %b lat %0d data %h, required 0 1 %h", obs_miss, obs_lat, obs_rdata, mem_word(32'hBFC0_0010));
    end
  endtask

  task automatic test_conflict();
    fetch(32'hBFC0_1004, 1, 0, -1);
    n_cmp++;
    if (obs_miss !== 1'b1) begin n_bad++; $display("FAIL conflict_miss: miss %b required 1", obs_miss); end
    fetch(32'hBFC0_0004, 0, 1, -1);
    n_cmp++;
    if (obs_miss !== 1'b1) begin n_bad++; $display("FAIL conflict_remiss: miss %b required 1", obs_miss); end
  endtask

  task automatic test_slow_axi();
    fetch(32'h0000_2468, 5, 2, -1);
    n_cmp++;
    if (obs_nwen != 8 || obs_narv != 6 || obs_lat != 12 + 5 + 14) begin
      n_bad++; $display("FAIL slow_axi: wen %0d arv %0d lat %0d, required 8 6 31", obs_nwen, obs_narv, obs_lat);
    end
  endtask

  task automatic test_back_to_back();
    int first_acc;
    fetch(32'h0000_2460, 0, 0, -1);
    first_acc = obs_acc;
    fetch(32'h0000_247C, 0, 0, -1);
    n_cmp++;
    if (obs_miss !== 1'b0 || obs_acc - first_acc != 2) begin
      n_bad++; $display("FAIL back_to_back: miss %b spacing %0d, required 0 2", obs_miss, obs_acc - first_acc);
    end
  endtask

  task automatic test_rst_mid_refill();
    fetch(32'h1234_5678, 0, 0, 3);
    n_cmp++;
    if (obs_aborted !== 1'b1) begin n_bad++; $display("FAIL abort_reached: aborted %b required 1", obs_aborted); end
    @(negedge clk);
    n_cmp++;
    if ({cpu_addr_ok, cpu_data_ok, tag_wen, dram_wen, arvalid, rready} !== 6'b0 || cpu_rdata !== 32'h0) begin
      n_bad++; $display("FAIL abort_reset_outputs: strobes %b rdata %h, required 000000 0",
                        {cpu_addr_ok, cpu_data_ok, tag_wen, dram_wen, arvalid, rready}, cpu_rdata);
    end
    fetch(32'h1234_5678, 0, 0, -1);
    n_cmp++;
    if (obs_miss !== 1'b1) begin n_bad++; $display("FAIL abort_line_invalid: miss %b required 1", obs_miss); end
  endtask

  task automatic test_random();
    logic [19:0] t;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       t = 20'h00001;
        1:       t = 20'h00002;
        default: t = 20'hBFC00;
      endcase
      a = {t, 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin tmem[i] = '0; ref_valid[i] = 0; ref_tag[i] = '0; end
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
    test_reset();
    test_cold_fetch();
    test_hit();
    test_conflict();
    test_slow_axi();
    test_back_to_back();
    test_rst_mid_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
